aes_ctr_sched: RTL and testbench

AES_CTR_SCHED -- requirements
Module: aes_ctr_sched

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_ctr_sched.sv | 129 ++++++++++++
 tb/tb_aes_ctr_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES counter-mode types: slice geometry and the
// sparse state encoding used by the counter scheduler.
package aes_pkg;

  localparam int SliceSizeCtr  = 16;
  localparam int CtrSlices     = 8;
  localparam int SliceIdxWidth = 3;
  localparam int BlockWidth    = SliceSizeCtr * CtrSlices;
  localparam int IvWords       = 4;

  // Pairwise Hamming distance >= 3 between all codes.
  typedef enum logic [5:0] {
    CTR_IDLE      = 6'b001110,
    CTR_READY     = 6'b110010,
    CTR_INCR_REQ  = 6'b010101,
    CTR_INCR_WAIT = 6'b101001,
    CTR_ERROR     = 6'b111111
  } ctr_state_e;

endpackage

// File: rtl/aes_ctr_sched.sv
// AES-CTR counter block scheduler: holds the counter,
// hands blocks to the cipher and sequences slice increments.
module aes_ctr_sched
  import aes_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IvWords-1:0]       iv_we_i,
  input  logic [BlockWidth-1:0]    iv_i,
  output logic                     ctr_valid_o,
  input  logic                     ctr_ready_i,
  output logic [BlockWidth-1:0]    ctr_block_o,
  output logic                     incr_o,
  input  logic                     fsm_ready_i,
  input  logic                     fsm_alert_i,
  input  logic [SliceIdxWidth-1:0] slice_idx_i,
  output logic [SliceSizeCtr-1:0]  slice_o,
  input  logic [SliceSizeCtr-1:0]  slice_i,
  input  logic                     slice_we_i,
  output logic                     iv_ignored_o,
  output logic                     alert_o
);

  ctr_state_e state_q, state_d;

  logic [BlockWidth-1:0] ctr_q, ctr_d;
  logic [IvWords-1:0]    flags_q, flags_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  first_q, first_d;
  logic                  ign_q, ign_d;
  logic                  iv_any;

  logic [CtrSlices-1:0][SliceSizeCtr-1:0] slices;

  assign slices       = ctr_q;
  assign slice_o      = slices[slice_idx_i];
  assign ctr_block_o  = ctr_q;
  assign iv_any       = |iv_we_i;

  assign ctr_valid_o  = (state_q == CTR_READY);
  assign incr_o       = (state_q == CTR_INCR_REQ) & fsm_ready_i;
  assign alert_o      = (state_q == CTR_ERROR);
  assign iv_ignored_o = ign_q;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    flags_d = flags_q;
    wcnt_d  = wcnt_q;
    first_d = 1'b0;
    ign_d   = 1'b0;

    unique case (state_q)
      CTR_IDLE: begin
        for (int k = 0; k < IvWords; k++) begin
          if (iv_we_i[k]) ctr_d[32*k +: 32] = iv_i[32*k +: 32];
        end
        flags_d = flags_q | iv_we_i;
        if (flags_q == '1) begin
          state_d = CTR_READY;
          flags_d = '0;
        end
      end
      CTR_READY: begin
        if (iv_any) begin
          for (int k = 0; k < IvWords; k++) begin
            if (iv_we_i[k]) ctr_d[32*k +: 32] = iv_i[32*k +: 32];
          end
          flags_d = iv_we_i;
          state_d = CTR_IDLE;
        end else if (ctr_ready_i) begin
          state_d = CTR_INCR_REQ;
        end
      end
      CTR_INCR_REQ: begin
        ign_d = iv_any;
        if (fsm_ready_i) begin
          state_d = CTR_INCR_WAIT;
          wcnt_d  = '0;
          first_d = 1'b1;
        end
      end
      CTR_INCR_WAIT: begin
        ign_d = iv_any;
        if (slice_we_i) begin
          for (int i = 0; i < CtrSlices; i++) begin
            if (slice_idx_i == i[SliceIdxWidth-1:0]) begin
              ctr_d[SliceSizeCtr*i +: SliceSizeCtr] = slice_i;
            end
          end
          wcnt_d = wcnt_q + 4'd1;
        end
        // Ready is still high from before the request on entry.
        if (!first_q && fsm_ready_i) begin
          state_d = (wcnt_q == 4'd8) ? CTR_READY : CTR_ERROR;
        end
      end
      CTR_ERROR: begin
        ign_d = iv_any;
      end
      default: begin
        state_d = CTR_ERROR;
      end
    endcase

    if (slice_we_i && state_q != CTR_INCR_WAIT) state_d = CTR_ERROR;
    if (fsm_alert_i) state_d = CTR_ERROR;
    if (state_d == CTR_ERROR) ctr_d = ctr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CTR_IDLE;
      ctr_q   <= '0;
      flags_q <= '0;
      wcnt_q  <= '0;
      first_q <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      flags_q <= flags_d;
      wcnt_q  <= wcnt_d;
      first_q <= first_d;
      ign_q   <= ign_d;
    end
  end

endmodule

// File: tb/tb_aes_ctr_sched.sv
// Scoreboard bench for aes_ctr_sched with a behavioural
// model of the external slice-increment FSM.
module tb_aes_ctr_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   iv_we;
  logic [127:0] iv;
  logic         ctr_valid;
  logic         ctr_ready;
  logic [127:0] ctr_block;
  logic         incr;
  logic         fsm_ready;
  logic         fsm_alert;
  logic [2:0]   slice_idx;
  logic [15:0]  slice_out;
  logic [15:0]  slice_in;
  logic         slice_we;
  logic         iv_ignored;
  logic         alert;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] model;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  aes_ctr_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .iv_we_i      (iv_we),
    .iv_i         (iv),
    .ctr_valid_o  (ctr_valid),
    .ctr_ready_i  (ctr_ready),
    .ctr_block_o  (ctr_block),
    .incr_o       (incr),
    .fsm_ready_i  (fsm_ready),
    .fsm_alert_i  (fsm_alert),
    .slice_idx_i  (slice_idx),
    .slice_o      (slice_out),
    .slice_i      (slice_in),
    .slice_we_i   (slice_we),
    .iv_ignored_o (iv_ignored),
    .alert_o      (alert)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    iv_we     = '0;
    iv        = '0;
    ctr_ready = 1'b0;
    fsm_ready = 1'b1;
    fsm_alert = 1'b0;
    slice_idx = '0;
    slice_in  = '0;
    slice_we  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 10 && !ctr_valid; i++) step();
    chk(tag, ctr_valid, 1'b1);
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv    = v;
    iv_we = 4'hf;
    step();
    iv_we = '0;
    wait_valid("load_valid");
    chk("load_block", ctr_block, v);
    model = v;
  endtask

  task automatic run_incr(input int nw, input bit inject,
                          input bit ok);
    int   n_incr;
    logic carry;
    logic [127:0] exp;
    n_incr = 0;
    if (ok) sb.push_back(model + 128'd1);
    ctr_ready = 1'b1;
    step();
    ctr_ready = 1'b0;
    fsm_ready = 1'b1;
    if (incr) n_incr++;
    step();
    if (incr) n_incr++;
    step();
    fsm_ready = 1'b0;
    carry = 1'b1;
    for (int i = 0; i < nw; i++) begin
      slice_idx = i[2:0];
      #1;
      slice_in = slice_out + {15'd0, carry};
      carry    = carry && (slice_out == 16'hffff);
      slice_we = 1'b1;
      if (inject && i == 1) begin
        iv    = {4{32'hdeadbeef}};
        iv_we = 4'b0001;
      end
      step();
      iv_we = '0;
      if (inject && i == 1) chk("iv_ign_pulse", iv_ignored, 1'b1);
      if (inject && i == 2) chk("iv_ign_clear", iv_ignored, 1'b0);
    end
    slice_we  = 1'b0;
    fsm_ready = 1'b1;
    step();
    chk("incr_pulses", n_incr, 1);
    if (ok) begin
      chk("incr_valid", ctr_valid, 1'b1);
      chk("incr_alert", alert, 1'b0);
      if (sb.size() == 0) begin
        chk("sb_empty", 1'b1, 1'b0);
      end else begin
        exp = sb.pop_front();
        chk("incr_block", ctr_block, exp);
        model = exp;
      end
    end else begin
      chk("err_alert", alert, 1'b1);
      chk("err_valid", ctr_valid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_valid", ctr_valid, 1'b0);
    chk("rst_alert", alert, 1'b0);
    chk("rst_incr", incr, 1'b0);
    chk("rst_ign", iv_ignored, 1'b0);
    chk("rst_block", ctr_block, 128'd0);

    // Scenario 1: zero IV, one increment.
    load_iv(128'd0);
    run_incr(8, 1'b0, 1'b1);
    chk("s1_block", ctr_block, 128'd1);
    slice_idx = 3'd0;
    #1;
    chk("s1_slice0", slice_out, 16'h0001);

    // Scenario 2: carry ripples into the top slice.
    load_iv({16'h0000, {112{1'b1}}});
    slice_idx = 3'd7;
    #1;
    chk("s2_slice7", slice_out, 16'h0000);
    slice_idx = 3'd6;
    #1;
    chk("s2_slice6", slice_out, 16'hffff);
    run_incr(8, 1'b0, 1'b1);
    chk("s2_block", ctr_block, {16'h0001, 112'd0});

    // Scenario 3: full wrap is legal.
    load_iv({128{1'b1}});
    run_incr(8, 1'b0, 1'b1);
    chk("s3_block", ctr_block, 128'd0);

    // Scenario 4: dropped IV write, then partial reload.
    load_iv(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978);
    run_incr(8, 1'b1, 1'b1);
    iv    = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    iv_we = 4'b0011;
    step();
    iv_we = '0;
    chk("s4_valid_drop", ctr_valid, 1'b0);
    step();
    step();
    step();
    chk("s4_valid_hold", ctr_valid, 1'b0);
    model = {model[127:64], 64'h3333_3333_4444_4444};
    iv    = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
    iv_we = 4'b1100;
    step();
    iv_we = '0;
    model = {64'h5555_5555_6666_6666, model[63:0]};
    wait_valid("s4_valid_back");
    chk("s4_block", ctr_block, model);
    run_incr(8, 1'b0, 1'b1);

    // Scenario 5: short increment is fatal until reset.
    run_incr(7, 1'b0, 1'b0);
    step();
    step();
    chk("s5_sticky", alert, 1'b1);
    iv_we = 4'b1000;
    step();
    iv_we = '0;
    chk("s5_ign_err", iv_ignored, 1'b1);
    do_reset();
    chk("s5_rst_alert", alert, 1'b0);
    chk("s5_rst_block", ctr_block, 128'd0);
    load_iv(128'h00ff);

    // Scenario 6: external alert, then reset mid-increment.
    fsm_alert = 1'b1;
    step();
    fsm_alert = 1'b0;
    chk("s6_alert", alert, 1'b1);
    chk("s6_valid", ctr_valid, 1'b0);
    do_reset();
    load_iv(128'habcd);
    ctr_ready = 1'b1;
    step();
    ctr_ready = 1'b0;
    step();
    step();
    fsm_ready = 1'b0;
    slice_idx = 3'd0;
    slice_in  = 16'h1234;
    slice_we  = 1'b1;
    step();
    rst      = 1'b1;
    slice_we = 1'b0;
    step();
    rst       = 1'b0;
    fsm_ready = 1'b1;
    chk("s6_rst_block", ctr_block, 128'd0);
    chk("s6_rst_valid", ctr_valid, 1'b0);
    chk("s6_rst_alert", alert, 1'b0);
    load_iv(128'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
